// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO and busy latency.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (ops 9-12).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  HILO_Op,
  input  logic [31:0] V1,
  input  logic [31:0] V2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO_Out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] shi, slo, shi_n, slo_n;
  logic [31:0] hi_n, lo_n;
  logic [63:0] base, res;
  logic        launch;

  logic op_mult, op_multu, op_div, op_divu;
  logic is_mul, is_md;

  assign op_mult  = (HILO_Op == OP_MULT);
  assign op_multu = (HILO_Op == OP_MULTU);
  assign op_div   = (HILO_Op == OP_DIV);
  assign op_divu  = (HILO_Op == OP_DIVU);

`ifdef MDU_MADD_EN
  logic op_madd, op_maddu, op_msub, op_msubu;
  assign op_madd  = (HILO_Op == OP_MADD);
  assign op_maddu = (HILO_Op == OP_MADDU);
  assign op_msub  = (HILO_Op == OP_MSUB);
  assign op_msubu = (HILO_Op == OP_MSUBU);
  assign is_mul = op_mult | op_multu | op_madd
                | op_maddu | op_msub | op_msubu;
`else
  assign is_mul = op_mult | op_multu;
`endif
  assign is_md = is_mul | op_div | op_divu;

  logic [63:0] ps, pu;
  assign ps = {{32{V1[31]}}, V1} * {{32{V2[31]}}, V2};
  assign pu = {32'b0, V1} * {32'b0, V2};

  // Divisor forced to 1 on zero or MIN/-1 so the divider never traps;
  // MIN/1 already yields the architected quotient MIN, remainder 0.
  logic        dz, ovf;
  logic [31:0] dv;
  logic [31:0] sq, sr, uq, ur;
  assign dz  = (V2 == 32'd0);
  assign ovf = (V1 == 32'h8000_0000) && (V2 == 32'hFFFF_FFFF);
  assign dv  = (dz || ovf) ? 32'd1 : V2;
  assign sq  = $signed(V1) / $signed(dv);
  assign sr  = $signed(V1) % $signed(dv);
  assign uq  = V1 / dv;
  assign ur  = V1 % dv;

  always_comb begin
    res = base;
    unique case (1'b1)
      op_mult:  res = ps;
      op_multu: res = pu;
      op_div:   if (!dz) res = {sr, sq};
      op_divu:  if (!dz) res = {ur, uq};
`ifdef MDU_MADD_EN
      op_madd:  res = base + ps;
      op_maddu: res = base + pu;
      op_msub:  res = base - ps;
      op_msubu: res = base - pu;
`endif
      default:  res = base;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shi_n   = shi;
    slo_n   = slo;
    hi_n    = HI;
    lo_n    = LO;
    base    = {HI, LO};
    launch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && is_md) launch = 1'b1;
        else if (HILO_Op == OP_MTHI) hi_n = V1;
        else if (HILO_Op == OP_MTLO) lo_n = V1;
      end
      BUSY: begin
        cnt_n = cnt - 16'd1;
        if (cnt == 16'd1) begin
          hi_n    = shi;
          lo_n    = slo;
          state_n = IDLE;
          // Back-to-back launch accumulates onto the value being committed.
          base    = {shi, slo};
          launch  = start && is_md;
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      state_n        = BUSY;
      cnt_n          = is_mul ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
      {shi_n, slo_n} = res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shi   <= '0;
      slo   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shi   <= shi_n;
      slo   <= slo_n;
      HI    <= hi_n;
      LO    <= lo_n;
    end
  end

  assign busy = (state == BUSY);

  always_comb begin
    HILO_Out = '0;
    if (HILO_Op == OP_MFHI) HILO_Out = HI;
    else if (HILO_Op == OP_MFLO) HILO_Out = LO;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed scoreboard bench for e_mdu.
// Expected commits are queued at issue; a negedge monitor checks them.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  HILO_Op = '0;
  logic [31:0] V1 = '0;
  logic [31:0] V2 = '0;
  logic        busy;
  logic [31:0] HI, LO, HILO_Out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   run = 0;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .HILO_Op(HILO_Op),
    .V1(V1),
    .V2(V2),
    .busy(busy),
    .HI(HI),
    .LO(LO),
    .HILO_Out(HILO_Out)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: measures each busy run and checks HI/LO when it ends.
  always @(negedge clk) begin
    if (!reset) run = 0;
    else if (busy) run++;
    else if (run > 0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_commit: got run %0d want none", run);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_len"}, run, e.len);
        chk({e.name, "_hi"}, HI, e.hi);
        chk({e.name, "_lo"}, LO, e.lo);
      end
      run = 0;
    end
  end

  task automatic push(input string n, input int len,
                      input logic [31:0] h, input logic [31:0] l);
    exp_t x;
    x.name = n;
    x.len = len;
    x.hi = h;
    x.lo = l;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    HILO_Op = op;
    V1 = a;
    V2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    HILO_Op = '0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    HILO_Op = op;
    V1 = a;
    @(posedge clk); #1;
    HILO_Op = '0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy %b want 0", name, busy);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_out", HILO_Out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    push("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle("mult");
    HILO_Op = 4'd7;
    #1 chk("mfhi", HILO_Out, 32'hFFFF_FFFF);
    HILO_Op = 4'd8;
    #1 chk("mflo", HILO_Out, 32'hFFFF_FFFE);
    HILO_Op = 4'd0;
    #1 chk("none_out", HILO_Out, 32'd0);

    push("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");

    push("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");

    mt(4'd5, 32'h1234_5678);
    mt(4'd6, 32'h1234_5678);
    chk("mt_lo", LO, 32'h1234_5678);
    push("divu0", 10, 32'h1234_5678, 32'h1234_5678);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle("divu0");

    push("divovf", 10, 32'h0000_0000, 32'h8000_0000);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("divovf");

    mt(4'd5, 32'hDEAD_BEEF);
    chk("mthi", HI, 32'hDEAD_BEEF);
    chk("mthi_busy", {31'b0, busy}, 32'd0);

    push("mult_neg", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    issue(4'd1, 32'hFFFF_FFFD, 32'd4);
    mt(4'd6, 32'hAAAA_5555);
    chk("mtlo_busy_ign", LO, 32'h8000_0000);
    wait_idle("mult_neg");

    issue(4'd1, 32'h0001_0000, 32'h0001_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_nocommit_hi", HI, 32'd0);
    chk("abort_nocommit_lo", LO, 32'd0);

    push("b2b", 10, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(4'd1, 32'd2, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    HILO_Op = 4'd3;
    V1 = 32'd100;
    V2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    HILO_Op = '0;
    @(posedge clk); #1;
    start = 1'b1;
    HILO_Op = 4'd2;
    V1 = 32'hFFFF_FFFF;
    V2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    HILO_Op = '0;
    chk("b2b_first_hi", HI, 32'd0);
    chk("b2b_first_lo", LO, 32'd6);
    chk("b2b_still_busy", {31'b0, busy}, 32'd1);
    wait_idle("b2b");

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
